tx_frame_gen: RTL and testbench
===============================

// Module: tx_frame_gen
// PURPOSE
// - Transmit-side framer: builds one Ethernet frame per tx_start from latched header fields plus a payload byte stream.
// - Sits between the TX payload buffer and the MAC AXI-stream TX port.
// - Emits 14 header bytes (dest MAC, src MAC, EtherType), then exactly pay_len payload bytes, with t_last on the final byte.
// PARAMETERS
// - MAX_PAYLOAD  1500  largest legal pay_len
// - MIN_PAYLOAD  46    pad target (used only with TX_PAD_EN)
// - LEN_W        11    width of pay_len and the payload counter
// PORTS
// - clk        in   1      clock
// - rst_n      in   1      reset, synchronous, active-low
// - tx_start   in   1      request one frame; sampled only in IDLE
// - dest_mac   in   48     destination MAC; latched on accepted tx_start
// - src_mac    in   48     source MAC; latched on accepted tx_start
// - eth_type   in   16     EtherType/length; latched on accepted tx_start
// - pay_len    in   LEN_W  payload byte count; latched on accepted tx_start
// - btx_data   in   8      payload byte from TX buffer
// - btx_valid  in   1      btx_data valid
// - btx_ready  out  1      payload byte consumed (pops buffer)
// - t_data     out  8      AXI-stream byte to MAC
// - t_valid    out  1      t_data valid
// - t_last     out  1      final byte of frame
// - t_ready    in   1      MAC accepts byte
// - busy       out  1      frame in progress (state != IDLE)
// - done       out  1      1-cycle pulse, cycle after final handshake
// - err        out  1      1-cycle pulse, tx_start rejected for bad length
// - frame_cnt  out  16     frames completed; wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: state IDLE; counters and latched fields 0; t_valid=t_last=btx_ready=busy=done=err=0; frame_cnt=0.
// - Transfer on t_valid & t_ready. Outputs are combinational from registered state/counters (payload path is zero-latency pass-through).
// - IDLE: t_valid=0, btx_ready=0.
//   - tx_start with 1<=pay_len<=MAX_PAYLOAD: latch fields, hdr_cnt=0, pay_cnt=0, go HEADER. First t_valid appears the next cycle.
//   - tx_start with pay_len==0 or >MAX_PAYLOAD: err=1 next cycle, stay IDLE.
// - HEADER: t_valid=1; t_data = header byte hdr_cnt.
//   - Byte order: dest_mac[47:40] first ... dest_mac[7:0], src_mac[47:40] ... src_mac[7:0], eth_type[15:8], eth_type[7:0].
//   - hdr_cnt increments per transfer. Transfer at hdr_cnt==13 -> PAYLOAD.
// - PAYLOAD: t_valid=btx_valid, t_data=btx_data, btx_ready=t_ready.
//   - pay_cnt increments per transfer.
//   - Last byte is pay_cnt==pay_len-1: t_last=1 (unless padding follows); transfer -> IDLE.
// - t_valid/t_data held stable until t_ready in HEADER/PAD; in PAYLOAD stability relies on the buffer's AXI compliance.
// - No t_ready timeout; t_ready low stalls indefinitely in any state.
// - Completion: done=1 for one cycle after the t_last transfer; frame_cnt increments on the same edge.
// - tx_start while busy: ignored, no err. Header/len inputs ignored while busy.
// - btx_ready is 0 outside PAYLOAD; buffer bytes are never consumed in HEADER/PAD.
// - Reset mid-frame: IDLE on the next edge. Partial frame left without t_last, no done, frame_cnt unchanged.
// CONFIGURATION
// - TX_PAD_EN defined:
//   - If pay_len<MIN_PAYLOAD, after the last payload transfer go PAD (no t_last on that byte).
//   - PAD: t_valid=1, t_data=8'h00; t_last on pad byte making total payload MIN_PAYLOAD; transfer -> IDLE.
//   - pay_len>=MIN_PAYLOAD: no padding.
// - TX_PAD_EN undefined: no PAD state; frames are emitted exactly pay_len payload bytes long; MIN_PAYLOAD unused.
// TESTING
// - dest=0x0A0B0C0D0E0F, src=0x112233445566, type=0x0800, len=4, t_ready=1 -> bytes 0A..0F,11..66,08,00,P0..P3.
//   t_last on byte 18 only; done pulse next cycle; frame_cnt=1.
// - Random t_ready/btx_valid stalls, len=64 -> 78 bytes, data held stable while stalled, btx_ready pops exactly 64.
// - pay_len=0 and pay_len=1501 -> err pulse each, busy stays 0, no t_valid.
// - tx_start pulsed mid-frame -> ignored. rst_n low at header byte 5 -> t_valid=0 next cycle, frame_cnt unchanged.
// - TX_PAD_EN, len=10 -> 10 payload + 36 zero bytes, t_last on byte 60. Without macro -> t_last on byte 24.
// - Preload frame_cnt to 0xFFFF via 65535 short frames (or force) + one frame -> frame_cnt=0.

Source files
------------

// File: rtl/tx_frame_gen_if.sv
// tx_frame_gen_if
// Purpose : bundles every signal of the transmit framer: the frame
//           request with its header fields, the payload byte stream
//           from the TX buffer, the byte stream towards the MAC and
//           the status outputs.
// Modports:
//   master - the framer: takes the request, header fields, btx_data,
//            btx_valid and t_ready; drives btx_ready, t_data, t_valid,
//            t_last, busy, done, err and frame_cnt.
//   slave  - the surroundings (TX buffer, MAC, controller): the
//            mirror image of master.
// Parameter: LEN_W - width of pay_len.
interface tx_frame_gen_if #(
    parameter int LEN_W = 11
);
    logic             tx_start;
    logic [47:0]      dest_mac;
    logic [47:0]      src_mac;
    logic [15:0]      eth_type;
    logic [LEN_W-1:0] pay_len;
    logic [7:0]       btx_data;
    logic             btx_valid;
    logic             btx_ready;
    logic [7:0]       t_data;
    logic             t_valid;
    logic             t_last;
    logic             t_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [15:0]      frame_cnt;

    modport master (
        input  tx_start, dest_mac, src_mac, eth_type, pay_len,
        input  btx_data, btx_valid, t_ready,
        output btx_ready, t_data, t_valid, t_last,
        output busy, done, err, frame_cnt
    );

    modport slave (
        output tx_start, dest_mac, src_mac, eth_type, pay_len,
        output btx_data, btx_valid, t_ready,
        input  btx_ready, t_data, t_valid, t_last,
        input  busy, done, err, frame_cnt
    );
endinterface

// File: rtl/tx_frame_gen.sv
// tx_frame_gen
// Purpose : transmit-side Ethernet framer. For each accepted tx_start it
//           sends the 14 header bytes (dest MAC, src MAC, EtherType, most
//           significant byte first) followed by pay_len payload bytes
//           taken straight from the TX buffer, with t_last on the final
//           byte of the frame.
// Ports   :
//   clk   - clock
//   rst_n - synchronous, active-low reset
//   bus   - tx_frame_gen_if.master: request and header fields, payload
//           stream in (btx_*), AXI-stream byte out (t_*), busy, done and
//           err pulses, 16-bit wrapping frame counter.
// Parameters: MAX_PAYLOAD (largest legal pay_len), MIN_PAYLOAD (pad
//           target), LEN_W (length/counter width).
// Build option: define TX_PAD_EN to zero-pad short payloads up to
//           MIN_PAYLOAD bytes; without it MIN_PAYLOAD is unused and
//           frames carry exactly pay_len payload bytes.
module tx_frame_gen #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int MIN_PAYLOAD = 46,
    parameter int LEN_W       = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    tx_frame_gen_if.master bus
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);
`ifdef TX_PAD_EN
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_PAYLOAD);
`endif

    typedef enum logic [1:0] {
`ifdef TX_PAD_EN
        PAD     = 2'd3,
`endif
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       hdrCnt_q;
    logic [LEN_W-1:0] payCnt_q;
    logic [47:0]      destMac_q;
    logic [47:0]      srcMac_q;
    logic [15:0]      ethType_q;
    logic [LEN_W-1:0] payLen_q;
    logic             done_q;
    logic             err_q;
    logic [15:0]      frameCnt_q;

    logic [111:0]     hdrWord;
    logic [7:0]       hdrByte;
    logic             lastPay;
    logic             padNeeded;
    logic             tValid;
    logic             tLast;
    logic [7:0]       tData;
    logic             btxReady;
    logic             xfer;

    // Header byte hdrCnt_q counts from the top of the 112-bit header word;
    // hdrCnt_q never exceeds 13, so the slice always stays in range.
    assign hdrWord = {destMac_q, srcMac_q, ethType_q};
    assign hdrByte = hdrWord[{4'd13 - hdrCnt_q, 3'b000} +: 8];
    assign lastPay = (payCnt_q == payLen_q - LEN_W'(1));

`ifdef TX_PAD_EN
    logic lastPad;
    assign padNeeded = (payLen_q < MIN_LEN);
    assign lastPad   = (payCnt_q == MIN_LEN - LEN_W'(1));
`else
    assign padNeeded = 1'b0;
`endif

    // Stream outputs are decoded from the registered state; in PAYLOAD the
    // buffer's valid/data go straight through and the MAC's ready pops it.
    always_comb begin
        tValid   = 1'b0;
        tLast    = 1'b0;
        tData    = 8'h00;
        btxReady = 1'b0;
        case (state_q)
            HEADER: begin
                tValid = 1'b1;
                tData  = hdrByte;
            end
            PAYLOAD: begin
                tValid   = bus.btx_valid;
                tData    = bus.btx_data;
                btxReady = bus.t_ready;
                tLast    = lastPay && !padNeeded;
            end
`ifdef TX_PAD_EN
            PAD: begin
                tValid = 1'b1;
                tLast  = lastPad;
            end
`endif
            default: begin
            end
        endcase
    end

    assign xfer = tValid && bus.t_ready;

    // Frame sequencer. payCnt_q keeps counting through the pad bytes so
    // that the pad ends when the total payload reaches MIN_PAYLOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hdrCnt_q   <= '0;
            payCnt_q   <= '0;
            destMac_q  <= '0;
            srcMac_q   <= '0;
            ethType_q  <= '0;
            payLen_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.tx_start) begin
                        if (bus.pay_len != '0 && bus.pay_len <= MAX_LEN) begin
                            destMac_q <= bus.dest_mac;
                            srcMac_q  <= bus.src_mac;
                            ethType_q <= bus.eth_type;
                            payLen_q  <= bus.pay_len;
                            hdrCnt_q  <= '0;
                            payCnt_q  <= '0;
                            state_q   <= HEADER;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        if (hdrCnt_q == 4'd13) begin
                            state_q <= PAYLOAD;
                        end else begin
                            hdrCnt_q <= hdrCnt_q + 4'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        payCnt_q <= payCnt_q + LEN_W'(1);
                        if (lastPay) begin
`ifdef TX_PAD_EN
                            if (padNeeded) begin
                                state_q <= PAD;
                            end else begin
                                state_q    <= IDLE;
                                done_q     <= 1'b1;
                                frameCnt_q <= frameCnt_q + 16'd1;
                            end
`else
                            state_q    <= IDLE;
                            done_q     <= 1'b1;
                            frameCnt_q <= frameCnt_q + 16'd1;
`endif
                        end
                    end
                end
`ifdef TX_PAD_EN
                PAD: begin
                    if (xfer) begin
                        payCnt_q <= payCnt_q + LEN_W'(1);
                        if (lastPad) begin
                            state_q    <= IDLE;
                            done_q     <= 1'b1;
                            frameCnt_q <= frameCnt_q + 16'd1;
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.t_valid   = tValid;
    assign bus.t_last    = tLast;
    assign bus.t_data    = tData;
    assign bus.btx_ready = btxReady;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.frame_cnt = frameCnt_q;
endmodule

// File: tb/tb_tx_frame_gen.sv
// tb_tx_frame_gen
// Purpose : self-checking bench for tx_frame_gen. A table of directed
//           frames and rejected lengths is followed by hand-written
//           sequences (reset mid-header, frame counter wrap) and by
//           randomly stalled frames. Expected byte streams are built
//           from the header fields and a random payload as plain queues.
// Build option: honours TX_PAD_EN the same way as the design.
module tb_tx_frame_gen;
    localparam int LEN_W  = 11;
    localparam int HDR    = 14;
    localparam int MINPAY = 46;
`ifdef TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] ety;
        int          len;
        int          readyPct;
        int          validPct;
        bit          expErr;
        int          expTotal;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;
    logic [15:0] expCnt;
    vec_t        vecs[10];

    tx_frame_gen_if #(.LEN_W(LEN_W)) bus ();

    tx_frame_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit start, input logic [47:0] d, input logic [47:0] s,
                                 input logic [15:0] ty, input logic [LEN_W-1:0] len);
        bus.tx_start = start;
        bus.dest_mac = d;
        bus.src_mac  = s;
        bus.eth_type = ty;
        bus.pay_len  = len;
    endtask

    function automatic int frameTotal(input int len);
        if (PAD_ON && len < MINPAY) return HDR + MINPAY;
        return HDR + len;
    endfunction

    // One complete frame with random stalls; junk requests and header
    // inputs are thrown at the design while it is busy.
    task automatic runFrame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] ty,
                            input int len, input int readyPct, input int validPct, input int expTotal);
        logic [7:0] expQ[$];
        logic [7:0] payQ[$];
        logic [7:0] b;
        int idx, popCnt, cyc, lastSeen, payIdx, payEnd;
        bit sawLast, bvHold, expValid, expLast, inPay;
        for (int i = 0; i < 6; i++) expQ.push_back(8'(d >> (40 - 8 * i)));
        for (int i = 0; i < 6; i++) expQ.push_back(8'(s >> (40 - 8 * i)));
        expQ.push_back(ty[15:8]);
        expQ.push_back(ty[7:0]);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            payQ.push_back(b);
            expQ.push_back(b);
        end
        if (PAD_ON) for (int i = len; i < MINPAY; i++) expQ.push_back(8'h00);
        payEnd = HDR + len;

        @(posedge clk); #1;
        applyStimulus(1'b1, d, s, ty, LEN_W'(len));
        bus.btx_valid = 1'b0;
        bus.t_ready   = 1'b0;
        bus.btx_data  = payQ[0];
        #1;
        checkOutput("start_t_valid", bus.t_valid, 0);
        checkOutput("start_busy", bus.busy, 0);

        idx = 0; popCnt = 0; cyc = 0; lastSeen = -1; sawLast = 0; bvHold = 0;
        forever begin
            @(posedge clk); #1;
            applyStimulus(!sawLast && ($urandom_range(0, 99) < 5), {$urandom, $urandom},
                          {$urandom, $urandom}, 16'($urandom), LEN_W'($urandom));
            bus.t_ready   = ($urandom_range(0, 99) < readyPct);
            bus.btx_valid = bvHold || ($urandom_range(0, 99) < validPct);
            payIdx = idx - HDR;
            if (payIdx < 0) payIdx = 0;
            if (payIdx > len - 1) payIdx = len - 1;
            bus.btx_data = payQ[payIdx];
            #1;
            if (sawLast) begin
                checkOutput("done_pulse", bus.done, 1);
                checkOutput("frame_cnt", bus.frame_cnt, expCnt);
                checkOutput("end_busy", bus.busy, 0);
                checkOutput("end_t_valid", bus.t_valid, 0);
                checkOutput("end_btx_ready", bus.btx_ready, 0);
                break;
            end
            checkOutput("busy", bus.busy, 1);
            checkOutput("done_early", bus.done, 0);
            checkOutput("err_busy", bus.err, 0);
            inPay    = (idx >= HDR) && (idx < payEnd);
            expValid = inPay ? bus.btx_valid : 1'b1;
            expLast  = (idx == expQ.size() - 1);
            checkOutput("t_valid", bus.t_valid, expValid);
            if (expValid) begin
                checkOutput("t_data", bus.t_data, expQ[idx]);
                checkOutput("t_last", bus.t_last, expLast);
            end
            checkOutput("btx_ready", bus.btx_ready, inPay ? bus.t_ready : 1'b0);
            if (bus.btx_ready && bus.btx_valid) popCnt++;
            bvHold = bus.btx_valid && !(inPay && bus.t_ready);
            if (expValid && bus.t_ready) begin
                if (bus.t_last) lastSeen = idx;
                idx++;
                if (idx == expQ.size()) begin
                    sawLast = 1;
                    expCnt  = expCnt + 16'd1;
                end
            end
            cyc++;
            if (cyc > expTotal * 30 + 100) begin
                checkOutput("frame_timeout", 1, 0);
                break;
            end
        end
        checkOutput("btx_pops", popCnt, len);
        checkOutput("last_index", 64'(lastSeen), 64'(expTotal - 1));
        bus.tx_start  = 1'b0;
        bus.btx_valid = 1'b0;
    endtask

    task automatic runReject(input logic [47:0] d, input logic [47:0] s, input logic [15:0] ty, input int len);
        @(posedge clk); #1;
        applyStimulus(1'b1, d, s, ty, LEN_W'(len));
        bus.t_ready = 1'b1;
        #1;
        checkOutput("rej_err_early", bus.err, 0);
        @(posedge clk); #1;
        bus.tx_start = 1'b0;
        #1;
        checkOutput("rej_err", bus.err, 1);
        checkOutput("rej_busy", bus.busy, 0);
        checkOutput("rej_t_valid", bus.t_valid, 0);
        @(posedge clk); #2;
        checkOutput("rej_err_clear", bus.err, 0);
        checkOutput("rej_busy_after", bus.busy, 0);
        checkOutput("rej_t_valid_after", bus.t_valid, 0);
    endtask

    task automatic runResetMid(input logic [47:0] d);
        @(posedge clk); #1;
        applyStimulus(1'b1, d, 48'h112233445566, 16'h0800, LEN_W'(8));
        bus.t_ready   = 1'b1;
        bus.btx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.tx_start = 1'b0;
            #1;
            checkOutput("rst_hdr_byte", bus.t_data, 8'(d >> (40 - 8 * i)));
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_hdr_byte5", bus.t_data, d[7:0]);
        checkOutput("rst_hdr_valid5", bus.t_valid, 1);
        @(posedge clk); #2;
        checkOutput("rst_t_valid", bus.t_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_frame_cnt", bus.frame_cnt, expCnt);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expCnt = 16'd0;
        vecs[0] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 4,    100, 100, 1'b0, PAD_ON ? 60 : 18};
        vecs[1] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 0,    100, 100, 1'b1, 0};
        vecs[2] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 1501, 100, 100, 1'b1, 0};
        vecs[3] = '{48'hFFFFFFFFFFFF, 48'h000000000001, 16'h86DD, 1,    100, 100, 1'b0, PAD_ON ? 60 : 15};
        vecs[4] = '{48'h010203040506, 48'hA1A2A3A4A5A6, 16'h0806, 10,   100, 100, 1'b0, PAD_ON ? 60 : 24};
        vecs[5] = '{48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0800, 45,   80,  80,  1'b0, PAD_ON ? 60 : 59};
        vecs[6] = '{48'hDEADBEEF0003, 48'hCAFEF00D0004, 16'h0800, 46,   80,  80,  1'b0, 60};
        vecs[7] = '{48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h0800, 64,   50,  60,  1'b0, 78};
        vecs[8] = '{48'h123456789ABC, 48'hFEDCBA987654, 16'h0800, 1500, 100, 100, 1'b0, 1514};
        vecs[9] = '{48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 2047, 100, 100, 1'b1, 0};

        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, '0);
        bus.btx_data  = 8'h00;
        bus.btx_valid = 1'b0;
        bus.t_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_t_valid", bus.t_valid, 0);
        checkOutput("reset_t_last", bus.t_last, 0);
        checkOutput("reset_btx_ready", bus.btx_ready, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_err", bus.err, 0);
        checkOutput("reset_frame_cnt", bus.frame_cnt, 0);
        rst_n = 1'b1;

        runResetMid(48'h0A0B0C0D0E0F);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].expErr)
                runReject(vecs[i].dest, vecs[i].src, vecs[i].ety, vecs[i].len);
            else
                runFrame(vecs[i].dest, vecs[i].src, vecs[i].ety, vecs[i].len,
                         vecs[i].readyPct, vecs[i].validPct, vecs[i].expTotal);
        end

        for (int i = 0; i < 12; i++) begin
            int len;
            len = $urandom_range(1, 100);
            runFrame({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), len,
                     $urandom_range(30, 100), $urandom_range(30, 100), frameTotal(len));
        end

        @(posedge clk); #1;
        force dut.frameCnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frameCnt_q;
        #1;
        checkOutput("preload_frame_cnt", bus.frame_cnt, 16'hFFFF);
        expCnt = 16'hFFFF;
        runFrame(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h0800, 4, 100, 100, frameTotal(4));
        checkOutput("wrap_frame_cnt", bus.frame_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
